// File: rtl/peripheral_bus_arbiter_pkg.sv
// Shared constants, state encoding and latched-transaction record for the
// peripheral register bus arbiter.
package peripheral_bus_pkg;

   localparam int PB_ADDR_W = 12;
   localparam int PB_DATA_W = 32;
   localparam int PB_SEL_W  = 4;

   typedef enum logic [1:0] {
      PB_IDLE,
      PB_BUS,
      PB_RESPOND
   } pb_state_e;

   typedef struct packed {
      logic                 we;
      logic [PB_ADDR_W-1:0] address;
      logic [PB_SEL_W-1:0]  byte_sel;
      logic [PB_DATA_W-1:0] data_write;
   } pb_txn_t;

   // A single requester still needs a 1-bit grant index.
   function automatic int pb_grant_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/peripheral_bus_arbiter_if.sv
// Requester handshake plus peripheral bus signals around the arbiter.
// The slave modport is the arbiter's view, master is the surrounding fabric.
interface peripheral_bus_arbiter_if #(
   parameter int REQUESTERS = 2
);
   import peripheral_bus_pkg::*;

   logic [REQUESTERS-1:0]           req_valid;
   logic [REQUESTERS-1:0]           req_we;
   logic [REQUESTERS*PB_ADDR_W-1:0] req_address;
   logic [REQUESTERS*PB_SEL_W-1:0]  req_byteSelect;
   logic [REQUESTERS*PB_DATA_W-1:0] req_dataWrite;
   logic [REQUESTERS-1:0]           req_ack;
   logic [PB_DATA_W-1:0]            req_dataRead;
   logic [REQUESTERS-1:0]           req_error;

   logic                            peripheralBus_we;
   logic                            peripheralBus_oe;
   logic [PB_ADDR_W-1:0]            peripheralBus_address;
   logic [PB_SEL_W-1:0]             peripheralBus_byteSelect;
   logic [PB_DATA_W-1:0]            peripheralBus_dataWrite;
   logic [PB_DATA_W-1:0]            peripheralBus_dataRead;
   logic                            peripheralBus_claimed;

   modport slave (
      input  req_valid, req_we, req_address, req_byteSelect, req_dataWrite,
      output req_ack, req_dataRead, req_error,
      output peripheralBus_we, peripheralBus_oe, peripheralBus_address,
             peripheralBus_byteSelect, peripheralBus_dataWrite,
      input  peripheralBus_dataRead, peripheralBus_claimed
   );

   modport master (
      output req_valid, req_we, req_address, req_byteSelect, req_dataWrite,
      input  req_ack, req_dataRead, req_error,
      input  peripheralBus_we, peripheralBus_oe, peripheralBus_address,
             peripheralBus_byteSelect, peripheralBus_dataWrite,
      output peripheralBus_dataRead, peripheralBus_claimed
   );

endinterface

// File: rtl/peripheral_bus_arbiter_rr.sv
// Combinational round-robin pick: first valid requester after last_grant_i,
// wrapping modulo N.
module round_robin_arbiter
   import peripheral_bus_pkg::*;
#(
   parameter int N  = 2,
   parameter int GW = pb_grant_w(N)
) (
   input  logic [N-1:0]  valid_i,
   input  logic [GW-1:0] last_grant_i,
   output logic [GW-1:0] grant_o,
   output logic          any_valid_o
);

   logic [GW-1:0] idx;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant_o     = '0;
      idx         = '0;
      any_valid_o = |valid_i;
      // Scan farthest to nearest so the closest valid master after last_grant_i wins.
      for (int off = N; off >= 1; off--) begin
         idx = GW'((int'(last_grant_i) + off) % N);
         if (valid_i[idx]) begin
            grant_o = idx;
         end
      end
   end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter for the 12-bit peripheral register bus: IDLE -> BUS -> RESPOND.
// Optional: define PERIPHERAL_BUS_UNCLAIMED_ERROR_EN to flag unclaimed reads on req_error.
module peripheral_bus_arbiter
   import peripheral_bus_pkg::*;
#(
   parameter int REQUESTERS = 2
) (
   input logic                 clk,
   input logic                 rst,
   peripheral_bus_arbiter_if.slave bus
);

   localparam int GW = pb_grant_w(REQUESTERS);

   pb_state_e            state_q, state_d;
   pb_txn_t              txn_q, txn_d;
   logic [GW-1:0]        grant_q, grant_d;
   logic [GW-1:0]        last_grant_q, last_grant_d;
   logic [PB_DATA_W-1:0] rdata_q;
`ifdef PERIPHERAL_BUS_UNCLAIMED_ERROR_EN
   logic                 claimed_q;
`endif

   logic [GW-1:0]        arb_grant;
   logic                 any_valid;

   round_robin_arbiter #(
      .N  (REQUESTERS),
      .GW (GW)
   ) u_rr (
      .valid_i      (bus.req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .any_valid_o  (any_valid)
   );

   always_comb begin
      state_d      = state_q;
      txn_d        = txn_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;

      bus.peripheralBus_we         = 1'b0;
      bus.peripheralBus_oe         = 1'b0;
      bus.peripheralBus_address    = '0;
      bus.peripheralBus_byteSelect = '0;
      bus.peripheralBus_dataWrite  = '0;
      bus.req_ack                  = '0;
      bus.req_dataRead             = '0;
      bus.req_error                = '0;

      unique case (state_q)
         PB_IDLE: begin
            if (any_valid) begin
               grant_d             = arb_grant;
               txn_d.we            = bus.req_we[arb_grant];
               txn_d.address       = bus.req_address[int'(arb_grant)*PB_ADDR_W +: PB_ADDR_W];
               txn_d.byte_sel      = bus.req_byteSelect[int'(arb_grant)*PB_SEL_W +: PB_SEL_W];
               txn_d.data_write    = bus.req_dataWrite[int'(arb_grant)*PB_DATA_W +: PB_DATA_W];
               state_d             = PB_BUS;
            end
         end
         PB_BUS: begin
            bus.peripheralBus_we         = txn_q.we;
            bus.peripheralBus_oe         = ~txn_q.we;
            bus.peripheralBus_address    = txn_q.address;
            bus.peripheralBus_byteSelect = txn_q.byte_sel;
            bus.peripheralBus_dataWrite  = txn_q.we ? txn_q.data_write : '0;
            state_d                      = PB_RESPOND;
         end
         PB_RESPOND: begin
            bus.req_ack[grant_q] = 1'b1;
            if (!txn_q.we) begin
`ifdef PERIPHERAL_BUS_UNCLAIMED_ERROR_EN
               if (claimed_q) begin
                  bus.req_dataRead = rdata_q;
               end else begin
                  bus.req_error[grant_q] = 1'b1;
               end
`else
               bus.req_dataRead = rdata_q;
`endif
            end
            last_grant_d = grant_q;
            state_d      = PB_IDLE;
         end
         default: state_d = PB_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= PB_IDLE;
         txn_q        <= '0;
         grant_q      <= '0;
         last_grant_q <= GW'(REQUESTERS - 1);
      end else begin
         state_q      <= state_d;
         txn_q        <= txn_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Read data and claim are sampled at the edge that closes the BUS cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q   <= '0;
`ifdef PERIPHERAL_BUS_UNCLAIMED_ERROR_EN
         claimed_q <= 1'b0;
`endif
      end else if (state_q == PB_BUS) begin
         rdata_q   <= bus.peripheralBus_dataRead;
`ifdef PERIPHERAL_BUS_UNCLAIMED_ERROR_EN
         claimed_q <= bus.peripheralBus_claimed;
`endif
      end
   end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed self-checking bench for peripheral_bus_arbiter (two requesters).
module tb_peripheral_bus_arbiter;
   import peripheral_bus_pkg::*;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   peripheral_bus_arbiter_if #(.REQUESTERS(N)) bus_if ();

   peripheral_bus_arbiter #(.REQUESTERS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int m, input logic v, input logic we, input logic [11:0] a,
                          input logic [3:0] s, input logic [31:0] d);
      bus_if.req_valid[m]                = v;
      bus_if.req_we[m]                   = we;
      bus_if.req_address[m*12 +: 12]     = a;
      bus_if.req_byteSelect[m*4 +: 4]    = s;
      bus_if.req_dataWrite[m*32 +: 32]   = d;
   endtask

   task automatic set_periph(input logic [31:0] d, input logic claimed);
      bus_if.peripheralBus_dataRead = d;
      bus_if.peripheralBus_claimed  = claimed;
   endtask

   task automatic check_bus(input string tag, input logic we, input logic oe, input logic [11:0] a,
                            input logic [3:0] s, input logic [31:0] d);
      check({tag, "_we"},   32'(bus_if.peripheralBus_we),         32'(we));
      check({tag, "_oe"},   32'(bus_if.peripheralBus_oe),         32'(oe));
      check({tag, "_addr"}, 32'(bus_if.peripheralBus_address),    32'(a));
      check({tag, "_sel"},  32'(bus_if.peripheralBus_byteSelect), 32'(s));
      check({tag, "_wdat"}, bus_if.peripheralBus_dataWrite,       d);
   endtask

   task automatic check_resp(input string tag, input logic [1:0] ack, input logic [31:0] d,
                             input logic [1:0] err);
      check({tag, "_ack"},  32'(bus_if.req_ack),   32'(ack));
      check({tag, "_rdat"}, bus_if.req_dataRead,   d);
      check({tag, "_err"},  32'(bus_if.req_error), 32'(err));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] unclaimed_err;
`ifdef PERIPHERAL_BUS_UNCLAIMED_ERROR_EN
      unclaimed_err = 2'b01;
`else
      unclaimed_err = 2'b00;
`endif
      bus_if.req_valid = '0;
      bus_if.req_we = '0;
      bus_if.req_address = '0;
      bus_if.req_byteSelect = '0;
      bus_if.req_dataWrite = '0;
      set_periph(32'h0, 1'b0);

      // Reset state
      #12;
      check_resp("rst", 2'b00, 32'h0, 2'b00);
      check_bus("rst", 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // 1: single write from m0
      set_req(0, 1'b1, 1'b1, 12'h120, 4'hF, 32'hDEADBEEF);
      tick();
      check_bus("t1_bus", 1'b1, 1'b0, 12'h120, 4'hF, 32'hDEADBEEF);
      check("t1_bus_ack", 32'(bus_if.req_ack), 32'h0);
      tick();
      check_resp("t1_rsp", 2'b01, 32'h0, 2'b00);
      check_bus("t1_rsp", 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      set_req(0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      tick();
      check_resp("t1_idle", 2'b00, 32'h0, 2'b00);

      // 2: read from m1, claimed
      set_req(1, 1'b1, 1'b0, 12'h120, 4'hF, 32'h0);
      set_periph(32'h12345678, 1'b1);
      tick();
      check_bus("t2_bus", 1'b0, 1'b1, 12'h120, 4'hF, 32'h0);
      tick();
      check_resp("t2_rsp", 2'b10, 32'h12345678, 2'b00);
      set_req(1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      set_periph(32'h0, 1'b0);
      tick();
      check_resp("t2_idle", 2'b00, 32'h0, 2'b00);

      // 3: both masters held valid after reset, grants alternate 0,1,0,1
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_bus("t3_rst", 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      set_req(0, 1'b1, 1'b1, 12'h010, 4'hF, 32'hA5A50000);
      set_req(1, 1'b1, 1'b0, 12'h020, 4'h3, 32'h0);
      set_periph(32'hCAFE0001, 1'b1);
      for (int k = 0; k < 4; k++) begin
         int m;
         m = k % 2;
         tick();
         if (m == 0) check_bus($sformatf("t3_bus%0d", k), 1'b1, 1'b0, 12'h010, 4'hF, 32'hA5A50000);
         else        check_bus($sformatf("t3_bus%0d", k), 1'b0, 1'b1, 12'h020, 4'h3, 32'h0);
         tick();
         check_resp($sformatf("t3_rsp%0d", k), (m == 0) ? 2'b01 : 2'b10,
                    (m == 0) ? 32'h0 : 32'hCAFE0001, 2'b00);
         check($sformatf("t3_rsp%0d_weoe", k),
               32'({bus_if.peripheralBus_we, bus_if.peripheralBus_oe}), 32'h0);
         if (k == 3) begin
            set_req(0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
            set_req(1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
         end
         tick();
         check($sformatf("t3_idle%0d_weoe", k),
               32'({bus_if.peripheralBus_we, bus_if.peripheralBus_oe}), 32'h0);
         check($sformatf("t3_idle%0d_ack", k), 32'(bus_if.req_ack), 32'h0);
      end
      tick();
      check("t3_quiet_weoe", 32'({bus_if.peripheralBus_we, bus_if.peripheralBus_oe}), 32'h0);
      set_periph(32'h0, 1'b0);

      // 4: unclaimed read, m0 wins since lastGrant=1
      set_req(0, 1'b1, 1'b0, 12'hFF0, 4'hF, 32'h0);
      tick();
      check_bus("t4_bus", 1'b0, 1'b1, 12'hFF0, 4'hF, 32'h0);
      tick();
      check_resp("t4_rsp", 2'b01, 32'h0, unclaimed_err);
      set_req(0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      tick();

      // 5: reset during the BUS cycle of a write
      set_req(0, 1'b1, 1'b1, 12'h0AB, 4'hF, 32'h55AA55AA);
      tick();
      check("t5_bus_we", 32'(bus_if.peripheralBus_we), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      check_bus("t5_abort", 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      set_req(0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      tick();
      check("t5_noack", 32'(bus_if.req_ack), 32'h0);
      rst = 1'b1;
      set_req(0, 1'b1, 1'b1, 12'h111, 4'hF, 32'h00000001);
      set_req(1, 1'b1, 1'b0, 12'h222, 4'hC, 32'h0);
      set_periph(32'h0BADF00D, 1'b1);
      tick();
      check_bus("t5_m0_bus", 1'b1, 1'b0, 12'h111, 4'hF, 32'h00000001);
      tick();
      check_resp("t5_m0_rsp", 2'b01, 32'h0, 2'b00);
      set_req(0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      tick();
      tick();
      check_bus("t5_m1_bus", 1'b0, 1'b1, 12'h222, 4'hC, 32'h0);
      tick();
      check_resp("t5_m1_rsp", 2'b10, 32'h0BADF00D, 2'b00);
      set_req(1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      tick();

      // 6: m0 drops valid right after IDLE sampling; byteSelect=0 passes through
      set_req(0, 1'b1, 1'b0, 12'h321, 4'h0, 32'h0);
      set_periph(32'h600D0006, 1'b1);
      tick();
      set_req(0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      check_bus("t6_bus", 1'b0, 1'b1, 12'h321, 4'h0, 32'h0);
      tick();
      check_resp("t6_rsp", 2'b01, 32'h600D0006, 2'b00);
      tick();
      tick();
      check_bus("t6_quiet", 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      check("t6_quiet_ack", 32'(bus_if.req_ack), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
